// File: rtl/vga_timing_pkg.sv
// Shared timing presets, region encoding and colour-bar table for the VGA timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {RegSync, RegBp, RegAct, RegFp} region_e;

  typedef struct packed {
    int unsigned sync;
    int unsigned bp;
    int unsigned act;
    int unsigned fp;
  } axis_timing_t;

  // Common presets: horizontal in pixel clocks, vertical in lines.
  localparam axis_timing_t H_640X480_60  = '{sync: 96,  bp: 48,  act: 640,  fp: 16};
  localparam axis_timing_t V_640X480_60  = '{sync: 2,   bp: 33,  act: 480,  fp: 10};
  localparam axis_timing_t H_800X600_60  = '{sync: 128, bp: 88,  act: 800,  fp: 40};
  localparam axis_timing_t V_800X600_60  = '{sync: 4,   bp: 23,  act: 600,  fp: 1};
  localparam axis_timing_t H_1024X768_60 = '{sync: 136, bp: 160, act: 1024, fp: 24};
  localparam axis_timing_t V_1024X768_60 = '{sync: 6,   bp: 29,  act: 768,  fp: 3};

  // Colour bar {R,G,B} on/off flags, left to right.
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] c;
    c = 3'b000;
    unique case (idx)
      3'd0: c = 3'b111;  // white
      3'd1: c = 3'b110;  // yellow
      3'd2: c = 3'b011;  // cyan
      3'd3: c = 3'b010;  // green
      3'd4: c = 3'b101;  // magenta
      3'd5: c = 3'b100;  // red
      3'd6: c = 3'b001;  // blue
      3'd7: c = 3'b000;  // black
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with region decode.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned SYNC = 136,
  parameter int unsigned BP   = 160,
  parameter int unsigned ACT  = 1024,
  parameter int unsigned FP   = 24,
  localparam int unsigned TOT = SYNC + BP + ACT + FP,
  localparam int unsigned CW  = $clog2(TOT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output region_e       region
);

  logic [CW-1:0] cnt_q;

  assign cnt  = cnt_q;
  assign wrap = adv && (cnt_q == CW'(TOT - 1));

  // Position counter; disabled axis is parked at 0 so a restart begins a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (adv) begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Region decode, compared at 32 bits so ACT ending exactly at TOT cannot overflow.
  always_comb begin
    region = RegFp;
    if (32'(cnt_q) < SYNC) begin
      region = RegSync;
    end else if (32'(cnt_q) < SYNC + BP) begin
      region = RegBp;
    end else if (32'(cnt_q) < SYNC + BP + ACT) begin
      region = RegAct;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with pixel-fetch request and registered outputs.
// Optional macro VGA_TESTPAT_EN adds VGA_PAT_SEL and an 8-bar colour test pattern.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned H_ACT    = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned V_ACT    = 768,
  parameter int unsigned V_FP     = 3,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned REQ_LEAD = 3,
  parameter int unsigned RGB_W    = 8,
  localparam int unsigned H_TOT   = H_SYNC + H_BP + H_ACT + H_FP,
  localparam int unsigned V_TOT   = V_SYNC + V_BP + V_ACT + V_FP,
  localparam int unsigned HCW     = $clog2(H_TOT),
  localparam int unsigned VCW     = $clog2(V_TOT)
) (
  input  logic               VGA_CLK,
  input  logic               VGA_RST_N,
  input  logic               VGA_EN,
  input  logic [3*RGB_W-1:0] VGA_BUF_RGB,
`ifdef VGA_TESTPAT_EN
  input  logic               VGA_PAT_SEL,
`endif
  output logic               VGA_REQ,
  output logic [HCW-1:0]     VGA_X,
  output logic [VCW-1:0]     VGA_Y,
  output logic               VGA_FRAME_START,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic               VGA_DE,
  output logic [RGB_W-1:0]   VGA_R,
  output logic [RGB_W-1:0]   VGA_G,
  output logic [RGB_W-1:0]   VGA_B,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N
);

  if (REQ_LEAD < 1 || REQ_LEAD > H_BP) begin : g_lead_chk
    $error("vga_timing_gen: REQ_LEAD must be in 1..H_BP");
  end

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           h_wrap;
  region_e        h_region, v_region;

  vga_axis_cnt #(.SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)) u_h_cnt (
    .clk    (VGA_CLK),
    .rst_n  (VGA_RST_N),
    .en     (VGA_EN),
    .adv    (1'b1),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .region (h_region)
  );

  // Frame wrap is implied by both counters returning to 0, so its flag is not needed here.
  vga_axis_cnt #(.SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)) u_v_cnt (
    .clk    (VGA_CLK),
    .rst_n  (VGA_RST_N),
    .en     (VGA_EN),
    .adv    (h_wrap),
    .cnt    (v_cnt),
    .wrap   (),
    .region (v_region)
  );

  logic [31:0]        h_lead;
  logic               de_d, req_d, fs_d, hsync_d, vsync_d;
  logic [HCW-1:0]     x_d;
  logic [VCW-1:0]     y_d;
  logic [3*RGB_W-1:0] rgb_d;

  logic               de_q, req_q, fs_q, hsync_q, vsync_q;
  logic [HCW-1:0]     x_q;
  logic [VCW-1:0]     y_q;
  logic [3*RGB_W-1:0] rgb_q;

`ifdef VGA_TESTPAT_EN
  logic [31:0] pix_col;
  logic [2:0]  bar_c;
`endif

  // Next-state of every output from the current counter state; request looks ahead on the
  // same line only, so it never wraps into the next line.
  always_comb begin
    h_lead  = 32'(h_cnt) + REQ_LEAD;
    de_d    = (h_region == RegAct) && (v_region == RegAct);
    req_d   = (h_lead >= H_SYNC + H_BP) && (h_lead < H_SYNC + H_BP + H_ACT) &&
              (v_region == RegAct);
    fs_d    = (h_cnt == '0) && (v_cnt == '0);
    hsync_d = (h_region == RegSync) ? H_POL : ~H_POL;
    vsync_d = (v_region == RegSync) ? V_POL : ~V_POL;
    x_d     = HCW'(h_lead - (H_SYNC + H_BP));
    y_d     = VCW'(32'(v_cnt) - (V_SYNC + V_BP));
    rgb_d   = de_d ? VGA_BUF_RGB : '0;
`ifdef VGA_TESTPAT_EN
    pix_col = 32'(h_cnt) - (H_SYNC + H_BP);
    bar_c   = bar_colour(3'((pix_col * 8) / H_ACT));
    if (VGA_PAT_SEL && de_d) begin
      rgb_d = {{RGB_W{bar_c[2]}}, {RGB_W{bar_c[1]}}, {RGB_W{bar_c[0]}}};
    end
`endif
  end

  // Output registers; disable forces the same values as reset. X/Y hold between requests.
  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) begin
      de_q    <= 1'b0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
    end else if (!VGA_EN) begin
      de_q    <= 1'b0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
    end else begin
      de_q    <= de_d;
      req_q   <= req_d;
      fs_q    <= fs_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
      if (req_d) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end

  assign VGA_DE          = de_q;
  assign VGA_BLANK_N     = de_q;
  assign VGA_REQ         = req_q;
  assign VGA_FRAME_START = fs_q;
  assign VGA_HSYNC       = hsync_q;
  assign VGA_VSYNC       = vsync_q;
  assign VGA_X           = x_q;
  assign VGA_Y           = y_q;
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_SYNC_N      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen on a small 17x16 raster.
module tb_vga_timing_gen;

  localparam int HS = 4, HB = 4, HA = 5, HF = 4;
  localparam int VS = 4, VB = 4, VA = 4, VF = 4;
  localparam int HT = 17, VT = 16, LEAD = 3;

  logic        clk, rst_n, en;
  logic [23:0] buf_rgb;
`ifdef VGA_TESTPAT_EN
  logic        pat_sel;
`endif

  logic       req, fs, hsync, vsync, de, blank_n, sync_n;
  logic [4:0] x;
  logic [3:0] y;
  logic [7:0] r, g, b;

  logic       p_req, p_fs, p_hsync, p_vsync, p_de, p_blank_n, p_sync_n;
  logic [4:0] p_x;
  logic [3:0] p_y;
  logic [7:0] p_r, p_g, p_b;

  int compared, mismatched;
  logic [4:0] last_x;
  logic [3:0] last_y;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .H_POL(1'b0), .V_POL(1'b0), .REQ_LEAD(LEAD), .RGB_W(8)
  ) dut (
    .VGA_CLK(clk), .VGA_RST_N(rst_n), .VGA_EN(en), .VGA_BUF_RGB(buf_rgb),
`ifdef VGA_TESTPAT_EN
    .VGA_PAT_SEL(pat_sel),
`endif
    .VGA_REQ(req), .VGA_X(x), .VGA_Y(y), .VGA_FRAME_START(fs),
    .VGA_HSYNC(hsync), .VGA_VSYNC(vsync), .VGA_DE(de),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n)
  );

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .H_POL(1'b1), .V_POL(1'b1), .REQ_LEAD(LEAD), .RGB_W(8)
  ) dut_pol (
    .VGA_CLK(clk), .VGA_RST_N(rst_n), .VGA_EN(en), .VGA_BUF_RGB(buf_rgb),
`ifdef VGA_TESTPAT_EN
    .VGA_PAT_SEL(pat_sel),
`endif
    .VGA_REQ(p_req), .VGA_X(p_x), .VGA_Y(p_y), .VGA_FRAME_START(p_fs),
    .VGA_HSYNC(p_hsync), .VGA_VSYNC(p_vsync), .VGA_DE(p_de),
    .VGA_R(p_r), .VGA_G(p_g), .VGA_B(p_b), .VGA_BLANK_N(p_blank_n), .VGA_SYNC_N(p_sync_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    compared += 9;
    if (hsync !== 1'b1) begin mismatched++; $display("FAIL rst_hsync got %b want 1", hsync); end
    if (vsync !== 1'b1) begin mismatched++; $display("FAIL rst_vsync got %b want 1", vsync); end
    if (de !== 1'b0 || blank_n !== 1'b0) begin
      mismatched++; $display("FAIL rst_de got %b/%b want 0/0", de, blank_n);
    end
    if (req !== 1'b0) begin mismatched++; $display("FAIL rst_req got %b want 0", req); end
    if (fs !== 1'b0) begin mismatched++; $display("FAIL rst_fs got %b want 0", fs); end
    if ({r, g, b} !== 24'h0) begin
      mismatched++; $display("FAIL rst_rgb got %h want 0", {r, g, b});
    end
    if (x !== 5'd0 || y !== 4'd0) begin
      mismatched++; $display("FAIL rst_xy got %0d,%0d want 0,0", x, y);
    end
    if (sync_n !== 1'b0) begin mismatched++; $display("FAIL sync_n got %b want 0", sync_n); end
    if (p_hsync !== 1'b0 || p_vsync !== 1'b0) begin
      mismatched++; $display("FAIL rst_pol_sync got %b%b want 00", p_hsync, p_vsync);
    end
  endtask

  // Runs one 272-cycle frame; caller guarantees the counters sit at (0,0) before the first edge.
  task automatic test_frame(input string tag);
    int h, v, de_cnt, req_cnt, runs, fs_cnt;
    logic prev_de, e_hs, e_vs, e_de, e_req, e_fs;
    logic [23:0] e_rgb, p1_d, p2_d;
    logic p1_v, p2_v;
    logic [7:0] cx, cy;
    de_cnt = 0; req_cnt = 0; runs = 0; fs_cnt = 0; prev_de = 1'b0;
    p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0;
    for (int k = 1; k <= HT * VT; k++) begin
      @(posedge clk);
      @(negedge clk);
      h = (k - 1) % HT;
      v = ((k - 1) / HT) % VT;
      e_hs  = !(h < HS);
      e_vs  = !(v < VS);
      e_de  = (h >= 8 && h < 13) && (v >= 8 && v < 12);
      e_req = (h >= 5 && h < 10) && (v >= 8 && v < 12);
      e_fs  = (h == 0) && (v == 0);
      if (e_req) begin
        last_x = 5'(h + LEAD - 8);
        last_y = 4'(v - 8);
      end
      cx = 8'(h - 8);
      cy = 8'(v - 8);
      e_rgb = e_de ? {cx, cy, cx ^ cy} : 24'h0;
      compared += 9;
      if (hsync !== e_hs) begin
        mismatched++; $display("FAIL %s hsync k=%0d got %b want %b", tag, k, hsync, e_hs);
      end
      if (vsync !== e_vs) begin
        mismatched++; $display("FAIL %s vsync k=%0d got %b want %b", tag, k, vsync, e_vs);
      end
      if (de !== e_de || blank_n !== e_de) begin
        mismatched++; $display("FAIL %s de k=%0d got %b want %b", tag, k, de, e_de);
      end
      if (req !== e_req) begin
        mismatched++; $display("FAIL %s req k=%0d got %b want %b", tag, k, req, e_req);
      end
      if (fs !== e_fs) begin
        mismatched++; $display("FAIL %s fs k=%0d got %b want %b", tag, k, fs, e_fs);
      end
      if (x !== last_x || y !== last_y) begin
        mismatched++;
        $display("FAIL %s xy k=%0d got %0d,%0d want %0d,%0d", tag, k, x, y, last_x, last_y);
      end
      if ({r, g, b} !== e_rgb) begin
        mismatched++; $display("FAIL %s rgb k=%0d got %h want %h", tag, k, {r, g, b}, e_rgb);
      end
      if (p_hsync !== !e_hs || p_vsync !== !e_vs) begin
        mismatched++;
        $display("FAIL %s pol_sync k=%0d got %b%b want %b%b", tag, k, p_hsync, p_vsync,
                 !e_hs, !e_vs);
      end
      if (p_de !== e_de || p_req !== e_req) begin
        mismatched++;
        $display("FAIL %s pol_de_req k=%0d got %b%b want %b%b", tag, k, p_de, p_req, e_de, e_req);
      end
      if (de && !prev_de) runs++;
      prev_de = de;
      if (de) de_cnt++;
      if (req) req_cnt++;
      if (fs) fs_cnt++;
      // Buffer model: answer each request two cycles later; junk otherwise.
      buf_rgb = p2_v ? p2_d : 24'hA5C35A;
      p2_v = p1_v; p2_d = p1_d;
      p1_v = req;
      p1_d = {8'(x), 8'(y), 8'(x) ^ 8'(y)};
    end
    compared += 4;
    if (de_cnt != 20) begin mismatched++; $display("FAIL %s de_total got %0d want 20", tag, de_cnt); end
    if (req_cnt != 20) begin
      mismatched++; $display("FAIL %s req_total got %0d want 20", tag, req_cnt);
    end
    if (runs != 4) begin mismatched++; $display("FAIL %s de_runs got %0d want 4", tag, runs); end
    if (fs_cnt != 1) begin mismatched++; $display("FAIL %s fs_total got %0d want 1", tag, fs_cnt); end
  endtask

  // Drop EN with the counters at h=10 of active line 1 (v=9), then restart a full frame.
  task automatic test_en_drop();
    repeat (9 * HT + 9 + 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    compared++;
    if (de !== 1'b1 || req !== 1'b1) begin
      mismatched++; $display("FAIL pre_drop de/req got %b%b want 11", de, req);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      compared += 4;
      if (de !== 1'b0 || req !== 1'b0 || fs !== 1'b0) begin
        mismatched++; $display("FAIL en_low[%0d] de/req/fs got %b%b%b want 000", i, de, req, fs);
      end
      if (hsync !== 1'b1 || vsync !== 1'b1) begin
        mismatched++; $display("FAIL en_low[%0d] sync got %b%b want 11", i, hsync, vsync);
      end
      if ({r, g, b} !== 24'h0 || x !== 5'd0 || y !== 4'd0) begin
        mismatched++;
        $display("FAIL en_low[%0d] rgb/xy got %h %0d %0d want 0", i, {r, g, b}, x, y);
      end
      if (p_hsync !== 1'b0 || p_vsync !== 1'b0) begin
        mismatched++; $display("FAIL en_low[%0d] pol_sync got %b%b want 00", i, p_hsync, p_vsync);
      end
    end
    last_x = '0;
    last_y = '0;
    en = 1'b1;
    test_frame("restart");
  endtask

  task automatic test_reset_mid();
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
    end
    compared++;
    if (vsync !== 1'b0) begin mismatched++; $display("FAIL pre_rst vsync got %b want 0", vsync); end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    last_x = '0;
    last_y = '0;
    test_frame("after_rst");
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    en = 1'b1;
    buf_rgb = '0;
    last_x = '0;
    last_y = '0;
`ifdef VGA_TESTPAT_EN
    pat_sel = 1'b0;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_frame("frame1");
    test_frame("back_to_back");
    test_en_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
